// File: rtl/dense_layer_pkg.sv
// Shared definitions for the dense layer output stages: FSM state type,
// default geometry of the neuron array and the index-width derivation.
package dense_layer_pkg;

    localparam int N_NEURONS_DEF = 128;
    localparam int IN_W_DEF      = 32;
    localparam int OUT_W_DEF     = 8;
    localparam int SHIFT_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPORT = 2'd2
    } act_state_e;

    // Width needed to index n elements; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dense_act_quant.sv
// Combinational activation/requantize stage: optional ReLU, arithmetic right
// shift by SHIFT, then signed saturation to OUT_W bits.
// Build option: define DENSE_ACT_RELU_EN to clamp negative inputs to zero
// before the shift; without it negatives shift and saturate symmetrically.
module dense_act_quant #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8
) (
    input  logic signed [IN_W-1:0]  x_i,
    output logic signed [OUT_W-1:0] y_o
);

    // Saturation bounds expressed at input width so the compare sees all bits.
    localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] relu_s;
    logic signed [IN_W-1:0] shift_s;

    // ReLU (when built in), arithmetic shift and clamp into the output range.
    always_comb begin
`ifdef DENSE_ACT_RELU_EN
        if (x_i[IN_W-1]) begin
            relu_s = {IN_W{1'b0}};
        end else begin
            relu_s = x_i;
        end
`else
        relu_s = x_i;
`endif
        shift_s = relu_s >>> SHIFT;
        if (shift_s > SAT_MAX) begin
            y_o = SAT_MAX[OUT_W-1:0];
        end else if (shift_s < SAT_MIN) begin
            y_o = SAT_MIN[OUT_W-1:0];
        end else begin
            y_o = shift_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/dense_act_stream.sv
// Output stage of the dense layer: snapshots all neuron outputs on a rising
// all_done, streams the quantized activations one per valid/ready beat and
// publishes the argmax once the final beat is accepted.
// Build option: DENSE_ACT_RELU_EN enables ReLU inside dense_act_quant.
module dense_act_stream
    import dense_layer_pkg::*;
#(
    parameter int N_NEURONS = N_NEURONS_DEF,
    parameter int IN_W      = IN_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int SHIFT     = SHIFT_DEF,
    localparam int IDX_W    = idx_width(N_NEURONS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      soft_clr,
    input  logic                      all_done,
    input  logic [N_NEURONS*IN_W-1:0] neuron_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_last,
    output logic                      busy,
    output logic                      result_valid,
    output logic [IDX_W-1:0]          argmax_idx,
    output logic [OUT_W-1:0]          argmax_val,
    output logic                      overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    act_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IN_W-1:0]         buf_q [N_NEURONS];

    logic                    all_done_prev_q;
    logic                    armed_q;
    logic                    rise_q;

    logic                    load_s;
    logic                    hs_s;
    logic [IN_W-1:0]         elem_s;
    logic signed [OUT_W-1:0] quant_s;

    logic signed [OUT_W-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;

    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_data_q;
    logic                    out_last_q;
    logic                    busy_q;
    logic                    result_valid_q;
    logic [IDX_W-1:0]        argmax_idx_q;
    logic signed [OUT_W-1:0] argmax_val_q;
    logic                    overrun_q;

    // Registered rising-edge detect on all_done. armed_q stays low until
    // all_done has been seen low once, so a level held high through reset
    // or soft clear cannot start a stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_done_prev_q <= 1'b0;
            armed_q         <= 1'b0;
            rise_q          <= 1'b0;
        end else if (soft_clr) begin
            all_done_prev_q <= 1'b0;
            armed_q         <= 1'b0;
            rise_q          <= 1'b0;
        end else begin
            all_done_prev_q <= all_done;
            armed_q         <= armed_q | ~all_done;
            rise_q          <= all_done & ~all_done_prev_q & armed_q;
        end
    end

    // Next-state logic: start on a detected edge, step on handshakes,
    // spend exactly one cycle in REPORT.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load_s  = 1'b0;
        hs_s    = out_valid_q & out_ready;
        case (state_q)
            IDLE: begin
                if (rise_q) begin
                    load_s  = 1'b1;
                    idx_d   = IDX_ZERO;
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (hs_s) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = IDX_ZERO;
                        state_d = REPORT;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            REPORT: begin
                idx_d   = IDX_ZERO;
                state_d = IDLE;
            end
            default: begin
                idx_d   = IDX_ZERO;
                state_d = IDLE;
            end
        endcase
    end

    // Element feeding the quantizer for the beat presented next cycle; on the
    // capture cycle the buffer is not yet written, so take element 0 directly.
    always_comb begin
        if (load_s) begin
            elem_s = neuron_in[IN_W-1:0];
        end else begin
            elem_s = buf_q[idx_d];
        end
    end

    dense_act_quant #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_quant (
        .x_i (elem_s),
        .y_o (quant_s)
    );

    // Running argmax: beat 0 loads, later beats replace only on strictly
    // greater, so ties keep the lowest index.
    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if ((state_q == STREAM) && hs_s) begin
            if ((idx_q == IDX_ZERO) || (out_data_q > best_val_q)) begin
                best_val_d = out_data_q;
                best_idx_d = idx_q;
            end else begin
                best_val_d = best_val_q;
                best_idx_d = best_idx_q;
            end
        end else begin
            best_val_d = best_val_q;
            best_idx_d = best_idx_q;
        end
    end

    // Snapshot buffer; only written on the capture cycle, so overrun edges
    // and soft clears leave the held values alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                buf_q[k] <= {IN_W{1'b0}};
            end
        end else if (load_s) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                buf_q[k] <= neuron_in[k*IN_W +: IN_W];
            end
        end
    end

    // State, index and registered outputs. The published argmax is latched on
    // the final handshake so it is already valid while result_valid pulses;
    // a soft clear aborts the stream but keeps the previously published result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= IDX_ZERO;
            out_valid_q    <= 1'b0;
            out_data_q     <= {OUT_W{1'b0}};
            out_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            best_val_q     <= {OUT_W{1'b0}};
            best_idx_q     <= IDX_ZERO;
            argmax_idx_q   <= IDX_ZERO;
            argmax_val_q   <= {OUT_W{1'b0}};
            overrun_q      <= 1'b0;
        end else if (soft_clr) begin
            state_q        <= IDLE;
            idx_q          <= IDX_ZERO;
            out_valid_q    <= 1'b0;
            out_data_q     <= {OUT_W{1'b0}};
            out_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            best_val_q     <= {OUT_W{1'b0}};
            best_idx_q     <= IDX_ZERO;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            out_valid_q    <= (state_d == STREAM);
            out_data_q     <= (state_d == STREAM) ? quant_s : {OUT_W{1'b0}};
            out_last_q     <= (state_d == STREAM) && (idx_d == LAST_IDX);
            busy_q         <= (state_d != IDLE);
            result_valid_q <= (state_d == REPORT);
            best_val_q     <= best_val_d;
            best_idx_q     <= best_idx_d;
            if ((state_q == STREAM) && (state_d == REPORT)) begin
                argmax_idx_q <= best_idx_d;
                argmax_val_q <= best_val_d;
            end
            overrun_q      <= overrun_q | (rise_q & (state_q != IDLE));
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_idx      = idx_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign argmax_idx   = argmax_idx_q;
    assign argmax_val   = argmax_val_q;
    assign overrun      = overrun_q;

endmodule
